// File: rtl/linescanner_sensor_emulator.sv
`default_nettype none
// ============================================================================
// Module   : linescanner_sensor_emulator
// Purpose  : Sensor-side responder to the linescanner capture unit: answers
//            rst_cds/sample with end_adc and load_pulse with an lval/data line.
//            Optional macro LINESCANNER_SENSOR_RAMP_PATTERN_EN selects a pixel
//            index ramp on data instead of PIXEL_CONSTANT.
// Revision : 1.0 - initial release
// ============================================================================
module linescanner_sensor_emulator #(
    parameter int          ADC_CONVERSION_CYCLES = 8,
    parameter int          END_ADC_HOLD_CYCLES   = 7,
    parameter int          LVAL_DELAY_CYCLES     = 50,
    parameter int          PIXELS_PER_LINE       = 250,
    parameter logic [7:0]  PIXEL_CONSTANT        = 8'hFF
) (
    input  logic       i_pixel_clock,
    input  logic       i_n_reset,
    input  logic       i_enable,
    input  logic       i_rst_cvc,
    input  logic       i_rst_cds,
    input  logic       i_sample,
    input  logic       i_load_pulse,
    output logic       o_end_adc,
    output logic       o_lval,
    output logic [7:0] o_data
);

    localparam int c_ADC_MAX  = (ADC_CONVERSION_CYCLES > END_ADC_HOLD_CYCLES) ?
                                ADC_CONVERSION_CYCLES : END_ADC_HOLD_CYCLES;
    localparam int c_ADC_W    = $clog2(c_ADC_MAX + 1);
    localparam int c_LINE_MAX = (LVAL_DELAY_CYCLES > PIXELS_PER_LINE) ?
                                LVAL_DELAY_CYCLES : PIXELS_PER_LINE;
    localparam int c_LINE_W   = $clog2(c_LINE_MAX + 1);

    localparam logic [c_ADC_W-1:0]  c_ADC_LAST   = c_ADC_W'(ADC_CONVERSION_CYCLES - 1);
    localparam logic [c_ADC_W-1:0]  c_HOLD_LAST  = c_ADC_W'(END_ADC_HOLD_CYCLES - 1);
    localparam logic [c_LINE_W-1:0] c_DELAY_LAST = c_LINE_W'(LVAL_DELAY_CYCLES - 1);
    localparam logic [c_LINE_W-1:0] c_PIX_LAST   = c_LINE_W'(PIXELS_PER_LINE - 1);

    typedef enum logic [1:0] {
        ADC_IDLE    = 2'd0,
        ADC_CONVERT = 2'd1,
        ADC_DONE    = 2'd2,
        ADC_HOLD    = 2'd3
    } adc_state_t;

    typedef enum logic [1:0] {
        LINE_IDLE   = 2'd0,
        LINE_DELAY  = 2'd1,
        LINE_ACTIVE = 2'd2
    } line_state_t;

    logic                r_rst_cvc_unused;
    logic                r_rst_cds_prev;
    logic                r_sample_prev;
    logic                r_load_prev;
    adc_state_t          r_adc_state;
    logic [c_ADC_W-1:0]  r_adc_cnt;
    logic                r_end_adc;
    line_state_t         r_line_state;
    logic [c_LINE_W-1:0] r_line_cnt;
    logic                r_lval;
    logic [7:0]          r_data;

    logic       w_cds_fall;
    logic       w_sample_fall;
    logic       w_load_rise;
    logic [7:0] w_first_pixel;
    logic [7:0] w_next_pixel;

    // History keeps tracking while disabled so re-enable never sees a stale edge.
    always_ff @(posedge i_pixel_clock) begin
        if (!i_n_reset) begin
            r_rst_cvc_unused <= 1'b0;
            r_rst_cds_prev   <= 1'b0;
            r_sample_prev    <= 1'b0;
            r_load_prev      <= 1'b0;
        end else begin
            r_rst_cvc_unused <= i_rst_cvc;
            r_rst_cds_prev   <= i_rst_cds;
            r_sample_prev    <= i_sample;
            r_load_prev      <= i_load_pulse;
        end
    end

    assign w_cds_fall    = r_rst_cds_prev & ~i_rst_cds;
    assign w_sample_fall = r_sample_prev  & ~i_sample;
    assign w_load_rise   = ~r_load_prev   &  i_load_pulse;

`ifdef LINESCANNER_SENSOR_RAMP_PATTERN_EN
    assign w_first_pixel = 8'h00;
    assign w_next_pixel  = r_data + 8'd1;
`else
    assign w_first_pixel = PIXEL_CONSTANT;
    assign w_next_pixel  = PIXEL_CONSTANT;
`endif

    always_ff @(posedge i_pixel_clock) begin
        if (!i_n_reset || !i_enable) begin
            r_adc_state <= ADC_IDLE;
            r_adc_cnt   <= '0;
            r_end_adc   <= 1'b0;
        end else begin
            case (r_adc_state)
                ADC_IDLE: begin
                    if (w_cds_fall) begin
                        r_adc_cnt   <= '0;
                        r_adc_state <= ADC_CONVERT;
                    end
                end
                ADC_CONVERT: begin
                    if (r_adc_cnt == c_ADC_LAST) begin
                        r_end_adc   <= 1'b1;
                        r_adc_cnt   <= '0;
                        r_adc_state <= ADC_DONE;
                    end else begin
                        r_adc_cnt <= r_adc_cnt + 1'b1;
                    end
                end
                ADC_DONE: begin
                    if (w_sample_fall) begin
                        r_adc_cnt   <= '0;
                        r_adc_state <= ADC_HOLD;
                    end
                end
                ADC_HOLD: begin
                    if (r_adc_cnt == c_HOLD_LAST) begin
                        r_end_adc   <= 1'b0;
                        r_adc_cnt   <= '0;
                        r_adc_state <= ADC_IDLE;
                    end else begin
                        r_adc_cnt <= r_adc_cnt + 1'b1;
                    end
                end
                default: begin
                    r_adc_state <= ADC_IDLE;
                end
            endcase
        end
    end

    // Pixel count restarts at lval rise so the last pixel is c_PIX_LAST.
    always_ff @(posedge i_pixel_clock) begin
        if (!i_n_reset || !i_enable) begin
            r_line_state <= LINE_IDLE;
            r_line_cnt   <= '0;
            r_lval       <= 1'b0;
            r_data       <= 8'h00;
        end else begin
            case (r_line_state)
                LINE_IDLE: begin
                    if (w_load_rise) begin
                        r_line_cnt   <= '0;
                        r_line_state <= LINE_DELAY;
                    end
                end
                LINE_DELAY: begin
                    if (r_line_cnt == c_DELAY_LAST) begin
                        r_lval       <= 1'b1;
                        r_data       <= w_first_pixel;
                        r_line_cnt   <= '0;
                        r_line_state <= LINE_ACTIVE;
                    end else begin
                        r_line_cnt <= r_line_cnt + 1'b1;
                    end
                end
                LINE_ACTIVE: begin
                    if (r_line_cnt == c_PIX_LAST) begin
                        r_lval       <= 1'b0;
                        r_data       <= 8'h00;
                        r_line_cnt   <= '0;
                        r_line_state <= LINE_IDLE;
                    end else begin
                        r_data     <= w_next_pixel;
                        r_line_cnt <= r_line_cnt + 1'b1;
                    end
                end
                default: begin
                    r_line_state <= LINE_IDLE;
                end
            endcase
        end
    end

    assign o_end_adc = r_end_adc;
    assign o_lval    = r_lval;
    assign o_data    = r_data;

endmodule
`default_nettype wire
